// File: rtl/accessor_if.sv
// Data-memory bus between the accessor (master) and the memory (slave).
// Handshake: the master raises mem_valid with mem_addr/mem_wstrb/mem_wdata and
// holds all of them stable until a rising edge where mem_ready is high; that edge
// completes the transfer, and mem_rdata is meaningful only in that cycle.
// mem_ready while mem_valid is low carries no meaning and is ignored.
interface accessor_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_wstrb,
      output mem_wdata,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_wstrb,
      input  mem_wdata,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/accessor.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, aligns and
// extends load data, traps misaligned accesses and hands results to writeback.
module accessor (
   input  logic                clk,
   input  logic                reset,
   input  logic                executor_valid,
   output logic                executor_ready,
   input  logic [3:0]          executor_op,
   input  logic [4:0]          executor_rd,
   input  logic [31:0]         executor_rd_data,
   input  logic [31:0]         executor_addr,
   input  logic [31:0]         executor_store_data,
   accessor_if.master          bus,
   output logic                accessor_valid,
   output logic [4:0]          accessor_rd,
   output logic [31:0]         accessor_rd_data,
   output logic                accessor_trap,
   output logic                state_dbg
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic {
      IDLE = 1'b0,
      MEM  = 1'b1
   } state_t;

   state_t      state;
   logic [3:0]  op_q;
   logic [4:0]  rd_q;
   logic [1:0]  lane_q;

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
      logic r;
      r = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: r = a[0];
         OP_LW, OP_SW:         r = (a != 2'b00);
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] a);
      logic [3:0] s;
      s = 4'b0000;
      case (op)
         OP_SB:   s = 4'b0001 << a;
         OP_SH:   s = a[1] ? 4'b1100 : 4'b0011;
         OP_SW:   s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
      logic [31:0] w;
      w = 32'd0;
      case (op)
         OP_SB:   w = {4{d[7:0]}};
         OP_SH:   w = {2{d[15:0]}};
         OP_SW:   w = d;
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Picks the addressed lane of the returned word and widens it to 32 bits.
   function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shifted = rdata >> {lane, 3'b000};
      b = shifted[7:0];
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      r = 32'd0;
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'd0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'd0, h};
         OP_LW:   r = rdata;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign executor_ready = reset && (state == IDLE);
   assign state_dbg      = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         op_q             <= 4'd0;
         rd_q             <= 5'd0;
         lane_q           <= 2'd0;
         bus.mem_valid    <= 1'b0;
         bus.mem_addr     <= 32'd0;
         bus.mem_wstrb    <= 4'd0;
         bus.mem_wdata    <= 32'd0;
         accessor_valid   <= 1'b0;
         accessor_rd      <= 5'd0;
         accessor_rd_data <= 32'd0;
         accessor_trap    <= 1'b0;
      end else begin
         accessor_valid <= 1'b0;
         accessor_trap  <= 1'b0;
         case (state)
            IDLE: begin
               if (executor_valid) begin
                  if (!is_load(executor_op) && !is_store(executor_op)) begin
                     accessor_valid   <= 1'b1;
                     accessor_rd      <= executor_rd;
                     accessor_rd_data <= executor_rd_data;
                  end else if (is_misaligned(executor_op, executor_addr[1:0])) begin
                     accessor_trap    <= 1'b1;
                     accessor_rd      <= 5'd0;
                     accessor_rd_data <= 32'd0;
                  end else begin
                     op_q          <= executor_op;
                     rd_q          <= executor_rd;
                     lane_q        <= executor_addr[1:0];
                     bus.mem_valid <= 1'b1;
                     bus.mem_addr  <= {executor_addr[31:2], 2'b00};
                     bus.mem_wstrb <= store_strobe(executor_op, executor_addr[1:0]);
                     bus.mem_wdata <= store_data(executor_op, executor_store_data);
                     state         <= MEM;
                  end
               end
            end
            MEM: begin
               // Request fields stay untouched here so they remain stable until accepted.
               if (bus.mem_ready) begin
                  bus.mem_valid    <= 1'b0;
                  accessor_valid   <= 1'b1;
                  accessor_rd      <= is_store(op_q) ? 5'd0 : rd_q;
                  accessor_rd_data <= load_result(op_q, lane_q, bus.mem_rdata);
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accessor.sv
// Directed bench for the accessor stage: NONE, loads, stores, traps,
// asynchronous reset during a bus request and back-to-back pass-through.
module tb_accessor;

   logic        clk;
   logic        reset;
   logic        executor_valid;
   logic        executor_ready;
   logic [3:0]  executor_op;
   logic [4:0]  executor_rd;
   logic [31:0] executor_rd_data;
   logic [31:0] executor_addr;
   logic [31:0] executor_store_data;
   logic        accessor_valid;
   logic [4:0]  accessor_rd;
   logic [31:0] accessor_rd_data;
   logic        accessor_trap;
   logic        state_dbg;

   int errors = 0;
   int checks = 0;

   accessor_if bus ();

   accessor dut (
      .clk                 (clk),
      .reset               (reset),
      .executor_valid      (executor_valid),
      .executor_ready      (executor_ready),
      .executor_op         (executor_op),
      .executor_rd         (executor_rd),
      .executor_rd_data    (executor_rd_data),
      .executor_addr       (executor_addr),
      .executor_store_data (executor_store_data),
      .bus                 (bus),
      .accessor_valid      (accessor_valid),
      .accessor_rd         (accessor_rd),
      .accessor_rd_data    (accessor_rd_data),
      .accessor_trap       (accessor_trap),
      .state_dbg           (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] rdd,
                        input logic [31:0] addr, input logic [31:0] sd);
      executor_valid      = 1'b1;
      executor_op         = op;
      executor_rd         = rd;
      executor_rd_data    = rdd;
      executor_addr       = addr;
      executor_store_data = sd;
   endtask

   task automatic mem_op(input string tag, input logic [3:0] op, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] sd, input int waits,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                         input logic [4:0] exp_rd, input logic [31:0] exp_data);
      drive(op, rd, 32'h5555_5555, addr, sd);
      step();
      executor_valid = 1'b0;
      chk({tag, " mem_valid"}, 32'(bus.mem_valid), 32'd1);
      chk({tag, " mem_addr"}, bus.mem_addr, exp_addr);
      chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_wstrb));
      chk({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
      chk({tag, " ready_low"}, 32'(executor_ready), 32'd0);
      chk({tag, " no_early_valid"}, 32'(accessor_valid), 32'd0);
      for (int i = 0; i < waits; i++) begin
         step();
         chk({tag, " wait mem_valid"}, 32'(bus.mem_valid), 32'd1);
         chk({tag, " wait mem_addr"}, bus.mem_addr, exp_addr);
         chk({tag, " wait ready_low"}, 32'(executor_ready), 32'd0);
         chk({tag, " wait no_valid"}, 32'(accessor_valid), 32'd0);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rdata;
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hFFFF_FFFF;
      chk({tag, " acc_valid"}, 32'(accessor_valid), 32'd1);
      chk({tag, " acc_trap"}, 32'(accessor_trap), 32'd0);
      chk({tag, " acc_rd"}, 32'(accessor_rd), 32'(exp_rd));
      chk({tag, " acc_data"}, accessor_rd_data, exp_data);
      chk({tag, " mem_valid_drop"}, 32'(bus.mem_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(executor_ready), 32'd1);
      step();
      chk({tag, " pulse_end"}, 32'(accessor_valid), 32'd0);
   endtask

   initial begin
      reset               = 1'b0;
      executor_valid      = 1'b0;
      executor_op         = 4'd0;
      executor_rd         = 5'd0;
      executor_rd_data    = 32'd0;
      executor_addr       = 32'd0;
      executor_store_data = 32'd0;
      bus.mem_ready       = 1'b0;
      bus.mem_rdata       = 32'd0;

      #1;
      chk("rst ready", 32'(executor_ready), 32'd0);
      chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      chk("rst acc_valid", 32'(accessor_valid), 32'd0);
      chk("rst acc_trap", 32'(accessor_trap), 32'd0);
      chk("rst acc_data", accessor_rd_data, 32'd0);
      step();
      step();
      reset = 1'b1;
      #1;
      chk("post_rst ready", 32'(executor_ready), 32'd1);

      // NONE pass-through
      drive(4'd0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
      step();
      executor_valid = 1'b0;
      chk("none acc_valid", 32'(accessor_valid), 32'd1);
      chk("none acc_rd", 32'(accessor_rd), 32'd5);
      chk("none acc_data", accessor_rd_data, 32'hDEAD_BEEF);
      chk("none mem_valid", 32'(bus.mem_valid), 32'd0);
      step();
      chk("none pulse_end", 32'(accessor_valid), 32'd0);

      // Loads and stores
      mem_op("lb", 4'd1, 5'd7, 32'h1003, 32'h0, 3, 32'h8011_2233,
             32'h1000, 4'b0000, 32'h0, 5'd7, 32'hFFFF_FF80);
      mem_op("lbu", 4'd4, 5'd8, 32'h1003, 32'h0, 3, 32'h8011_2233,
             32'h1000, 4'b0000, 32'h0, 5'd8, 32'h0000_0080);
      mem_op("sh", 4'd7, 5'd9, 32'h2002, 32'h0000_ABCD, 0, 32'h0,
             32'h2000, 4'b1100, 32'hABCD_ABCD, 5'd0, 32'h0);
      mem_op("sb", 4'd6, 5'd10, 32'h2001, 32'h1234_5678, 1, 32'h0,
             32'h2000, 4'b0010, 32'h7878_7878, 5'd0, 32'h0);
      mem_op("lh", 4'd2, 5'd11, 32'h1002, 32'h0, 0, 32'h8011_2233,
             32'h1000, 4'b0000, 32'h0, 5'd11, 32'hFFFF_8011);
      mem_op("lhu", 4'd5, 5'd12, 32'h1000, 32'h0, 2, 32'h1234_F00D,
             32'h1000, 4'b0000, 32'h0, 5'd12, 32'h0000_F00D);
      mem_op("lw", 4'd3, 5'd13, 32'h4000, 32'h0, 1, 32'hCAFE_F00D,
             32'h4000, 4'b0000, 32'h0, 5'd13, 32'hCAFE_F00D);
      mem_op("sw", 4'd8, 5'd14, 32'h4004, 32'h0BAD_CAFE, 0, 32'h0,
             32'h4004, 4'b1111, 32'h0BAD_CAFE, 5'd0, 32'h0);

      // Misaligned LW traps, then a NONE is accepted on the very next cycle
      drive(4'd3, 5'd4, 32'h0, 32'h3001, 32'h0);
      step();
      chk("trap acc_trap", 32'(accessor_trap), 32'd1);
      chk("trap acc_valid", 32'(accessor_valid), 32'd0);
      chk("trap acc_rd", 32'(accessor_rd), 32'd0);
      chk("trap mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("trap ready", 32'(executor_ready), 32'd1);
      drive(4'd9, 5'd6, 32'h0000_0011, 32'h0, 32'h0);
      step();
      chk("after_trap acc_trap", 32'(accessor_trap), 32'd0);
      chk("after_trap acc_valid", 32'(accessor_valid), 32'd1);
      chk("after_trap acc_rd", 32'(accessor_rd), 32'd6);
      chk("after_trap acc_data", accessor_rd_data, 32'h0000_0011);
      chk("after_trap mem_valid", 32'(bus.mem_valid), 32'd0);

      // Misaligned SH also traps
      drive(4'd7, 5'd3, 32'h0, 32'h2003, 32'hFFFF);
      step();
      executor_valid = 1'b0;
      chk("sh_trap acc_trap", 32'(accessor_trap), 32'd1);
      chk("sh_trap mem_valid", 32'(bus.mem_valid), 32'd0);
      step();
      chk("sh_trap pulse_end", 32'(accessor_trap), 32'd0);

      // Reset during a pending request
      drive(4'd8, 5'd2, 32'h0, 32'h5000, 32'h1111_2222);
      step();
      executor_valid = 1'b0;
      chk("rmem mem_valid", 32'(bus.mem_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rmem async mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rmem async mem_addr", bus.mem_addr, 32'd0);
      chk("rmem async mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rmem async mem_wdata", bus.mem_wdata, 32'd0);
      chk("rmem async ready", 32'(executor_ready), 32'd0);
      step();
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      step();
      chk("rmem no_stale_valid", 32'(accessor_valid), 32'd0);
      chk("rmem ready", 32'(executor_ready), 32'd1);
      chk("rmem mem_valid", 32'(bus.mem_valid), 32'd0);
      bus.mem_ready = 1'b0;

      // Back-to-back NONE with executor_valid held high
      drive(4'd0, 5'd1, 32'h0000_00A0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b2b acc_valid", 32'(accessor_valid), 32'd1);
         chk("b2b acc_rd", 32'(accessor_rd), 32'(i + 1));
         chk("b2b acc_data", accessor_rd_data, 32'h0000_00A0 + 32'(i));
         executor_rd      = 5'(i + 2);
         executor_rd_data = 32'h0000_00A0 + 32'(i + 1);
      end
      executor_valid = 1'b0;
      step();
      chk("b2b pulse_end", 32'(accessor_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
